stream_mux_rr: RTL

Parametrised N-channel streaming multiplexer, the successor to the 2:1 combinational mux. Each input has a valid/ready handshake. A round-robin or fixed-select arbiter picks one channel per beat, and the selected beat goes into a single registered output stage with valid/ready back-pressure. It sits between multiple producer streams and one shared consumer in the datapath.

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/stream_mux_rr.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Types and constants shared by the streaming multiplexer and its arbiter:
//   MODE_RR / MODE_FIXED : arbitration mode encoding on the `mode` input
//   lock_state_t         : packet-lock FSM states (used when STREAM_MUX_LAST_EN is defined)
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational one-hot grant for stream_mux_rr.
// Ports:
//   in_valid    : per-channel request
//   rr_ptr      : first channel searched in round-robin mode
//   mode        : MODE_RR or MODE_FIXED
//   fix_sel     : granted channel in fixed mode (no grant if out of range)
//   lock_active : a packet is in progress, only lock_ch may be granted
//   lock_ch     : channel owning the current packet
//   grant       : one-hot grant, always a subset of in_valid
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] in_valid,
  input  logic [CH_W-1:0] rr_ptr,
  input  logic            mode,
  input  logic [CH_W-1:0] fix_sel,
  input  logic            lock_active,
  input  logic [CH_W-1:0] lock_ch,
  output logic [N_CH-1:0] grant
);

  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    if (lock_active) begin
      // a packet in flight overrides both arbitration modes
      grant[lock_ch] = in_valid[lock_ch];
    end else if (mode == MODE_FIXED) begin
      if (int'(fix_sel) < N_CH) begin
        grant[fix_sel] = in_valid[fix_sel];
      end
    end else begin
      // ascending search starting at rr_ptr, wrapping past the last channel
      for (int i = 0; i < N_CH; i++) begin
        idx = CH_W'((int'(rr_ptr) + i) % N_CH);
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration and a single registered output stage.
// Optional feature macro: STREAM_MUX_LAST_EN -- adds in_last/out_last and a
// packet-lock FSM that keeps the grant on one channel until its last beat.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mode, fix_sel       : arbitration mode and fixed-mode channel
//   in_valid/in_ready   : per-channel handshake (in_ready is combinational)
//   in_data             : packed per-channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last             : per-channel end-of-packet (STREAM_MUX_LAST_EN)
//   out_valid/out_ready : output handshake
//   out_data, out_ch    : registered beat and its source channel
//   out_last            : registered end-of-packet (STREAM_MUX_LAST_EN)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [CH_W-1:0]       fix_sel,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_LAST_EN
  input  logic [N_CH-1:0]       in_last,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef STREAM_MUX_LAST_EN
  output logic                  out_last,
`endif
  output logic [CH_W-1:0]       out_ch
);

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
    return (int'(ch) == N_CH - 1) ? '0 : ch + 1'b1;
  endfunction

  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  rr_ptr;
  logic             load_en;
  logic             transfer;
  logic [CH_W-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             lock_active;
  logic [CH_W-1:0]  lock_ch;

  assign load_en  = !out_valid || out_ready;
  // gating with rst keeps the producers from seeing a handshake during reset
  assign in_ready = grant & {N_CH{load_en & !rst}};
  assign transfer = |(in_valid & in_ready);

  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .in_valid    (in_valid),
    .rr_ptr      (rr_ptr),
    .mode        (mode),
    .fix_sel     (fix_sel),
    .lock_active (lock_active),
    .lock_ch     (lock_ch),
    .grant       (grant)
  );

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ready[i]) begin
        sel_idx  = CH_W'(i);
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef STREAM_MUX_LAST_EN
  lock_state_t state_q, state_d;
  logic        sel_last;

  assign sel_last    = in_last[sel_idx];
  assign lock_active = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (transfer) begin
      case (state_q)
        IDLE:    if (!sel_last) state_d = LOCKED;
        LOCKED:  if (sel_last)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else if (transfer) begin
      if (state_q == IDLE) begin
        lock_ch <= sel_idx;
        if (mode == MODE_RR) rr_ptr <= ch_inc(sel_idx);
      end else if (sel_last) begin
        // the packet owner goes to the back of the queue, whatever the mode
        rr_ptr <= ch_inc(lock_ch);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_last <= 1'b0;
    else if (transfer) out_last <= sel_last;
  end
`else
  assign lock_active = 1'b0;
  assign lock_ch     = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rr_ptr <= '0;
    else if (transfer && mode == MODE_RR) rr_ptr <= ch_inc(sel_idx);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
